// File: rtl/systolic_pkg.sv
// Shared defaults, FSM state encoding and lane slicing helper for the
// systolic array edge feeders.
package systolic_pkg;

    localparam int unsigned N_DEF    = 4;
    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned MAXK_DEF = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int unsigned lane_idx(input int unsigned lane, input int unsigned dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Enabled shift chain of DEPTH stages, each carrying an operand plus a valid bit.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o
);

    localparam int unsigned SW = DEPTH * (DW + 1);

    // Stage 0 sits in the low slice; each shift pushes older stages upward.
    logic [SW-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else if (en_i) begin
            chain_q <= SW'({chain_q, valid_i, data_i});
        end
    end

    assign valid_o = chain_q[SW-1];
    assign data_o  = chain_q[SW-2 -: DW];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Accepts N-lane operand beats and presents them diagonally skewed on the
// systolic array edge, then drains the skew with zeros and pulses done.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned MAXK = MAXK_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [N*DW-1:0]            s_data,
    input  logic                       s_last,
    input  logic                       hold,
    output logic [N*DW-1:0]            edge_data,
    output logic [N-1:0]               edge_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(MAXK+1)-1:0]  beat_cnt
);

    localparam int unsigned CW = $clog2(MAXK + 1);
    localparam int unsigned FW = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAXK);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(N - 2);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [0:0]    status_q, status_d;
    logic          done_q, busy_q;
    logic          accept, tile_end;

    assign s_ready = !hold && (state_q == IDLE || state_q == FEED);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fcnt_d   = fcnt_q;
        status_d = status_q;
        cnt_inc  = cnt_q + 1'b1;
        tile_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d    = CW'(1);
                    state_d  = FEED;
                    tile_end = s_last || (CNT_MAX == CW'(1));
                end
            end
            FEED: begin
                if (accept) begin
                    cnt_d    = cnt_inc;
                    tile_end = s_last || (cnt_inc == CNT_MAX);
                end
            end
            FLUSH: begin
                if (!hold) begin
                    if (fcnt_q == FLUSH_LAST) begin
                        state_d = DONE;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A single-lane feeder has no skew to drain, so the last beat ends the tile.
        if (tile_end) begin
            state_d = (N == 1) ? DONE : FLUSH;
            fcnt_d  = '0;
            if (!s_last) begin
                status_d[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fcnt_q   <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fcnt_q   <= fcnt_d;
            status_q <= status_d;
            done_q   <= (state_d == DONE);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign done     = done_q;
    assign busy     = busy_q;
    assign beat_cnt = cnt_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] lane_data;

        assign lane_data = accept ? s_data[lane_idx(i, DW) +: DW] : '0;

        skew_delay_line #(
            .DEPTH (i + 1),
            .DW    (DW)
        ) u_delay (
            .clk_i   (clk),
            .rst_ni  (rst),
            .en_i    (!hold),
            .data_i  (lane_data),
            .valid_i (accept),
            .data_o  (edge_data[lane_idx(i, DW) +: DW]),
            .valid_o (edge_valid[i])
        );
    end

endmodule
